ps2_key_event_queue: RTL and testbench

Converts the raw PS/2 scan-byte stream from the keyboard receiver into decoded key events (make/break, extended flag, code), suppresses typematic repeats for up to HELD_SLOTS simultaneously held keys, and buffers events in a DEPTH-entry FIFO with a ready/valid output. Sits between the PS/2 receiver and the ASCII/UART formatting path. It replaces the single-last-keycode change detector, which mis-handles multiple held keys.

---
 rtl/ps2_evt_pkg.sv | 37 +++
 rtl/ps2_evt_fifo.sv | 82 ++++++++
 rtl/ps2_key_event_queue.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_key_event_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_evt_pkg.sv
// Shared types and constants for the PS/2 key event queue.
package ps2_evt_pkg;

    localparam int unsigned EVT_W  = 10;
    localparam int unsigned CODE_W = 8;

    // Scan-code parser position within a make/break sequence
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Decoded key event as it sits in the queue
    typedef struct packed {
        logic              ext;
        logic              brk;
        logic [CODE_W-1:0] code;
    } ps2_event_t;

    // Keyboard status/error bytes that never form part of a key sequence
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_ACK)    || (b == PS2_BAT)  || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO with a registered head word; a push into a full FIFO
// is accepted when a pop happens in the same cycle. Sticky overflow on drop.
module ps2_evt_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     ready,
    output logic                     valid,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [LW-1:0]    level_nxt;
    logic [WIDTH-1:0] rdata_nxt;
    logic             pop;
    logic             full;
    logic             accept;

    // Handshake, occupancy and next head word
    always_comb begin
        pop        = valid && ready;
        full       = (level == LW'(DEPTH));
        accept     = push && (!full || pop);
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        level_nxt  = level;
        if (accept && !pop) begin
            level_nxt = level + LW'(1);
        end else if (!accept && pop) begin
            level_nxt = level - LW'(1);
        end
        if (level_nxt == '0) begin
            rdata_nxt = '0;
        end else if (accept && (wr_ptr == rd_ptr_nxt)) begin
            rdata_nxt = wdata;
        end else begin
            rdata_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy, registered head and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            valid    <= 1'b0;
            rdata    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            valid  <= (level_nxt != '0);
            rdata  <= rdata_nxt;
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-byte parser with optional typematic repeat filter and event FIFO.
// Define PS2_EVT_REPEAT_FILTER_EN to build the held-key table.
module ps2_key_event_queue
    import ps2_evt_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned HELD_SLOTS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EVT_W-1:0]       out_event,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [3:0]             held_count,
    output logic                   overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (HELD_SLOTS < 1 || HELD_SLOTS > 8) begin : g_bad_slots
        $error("HELD_SLOTS must be between 1 and 8");
    end

    ps2_state_e    state;
    ps2_state_e    state_nxt;
    logic [TW-1:0] idle_cnt;
    logic          timeout;
    logic          emit;
    ps2_event_t    evt;
    logic          push;

    assign timeout = (state != ST_IDLE) && !in_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Parser state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Parser next state; duplicate prefixes hold the current state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_data == PS2_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (in_data == PS2_BRK) begin
                        state_nxt = ST_BRK;
                    end
                end
            end
            ST_EXT: begin
                if (in_valid) begin
                    if (in_data == PS2_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (in_data != PS2_EXT) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BRK, ST_EXT_BRK: begin
                if (in_valid) begin
                    if (in_data != PS2_BRK) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Parser event output for the current byte
    always_comb begin
        emit     = 1'b0;
        evt      = '0;
        evt.code = in_data;
        if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    emit = (in_data != PS2_EXT) && (in_data != PS2_BRK) && !is_discard(in_data);
                end
                ST_EXT: begin
                    emit    = (in_data != PS2_EXT) && (in_data != PS2_BRK);
                    evt.ext = 1'b1;
                end
                ST_BRK: begin
                    emit    = (in_data != PS2_BRK);
                    evt.brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    emit    = (in_data != PS2_BRK);
                    evt.ext = 1'b1;
                    evt.brk = 1'b1;
                end
                default: emit = 1'b0;
            endcase
        end
    end

    // Idle-cycle counter that abandons a stalled prefix sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (in_valid || (state == ST_IDLE) || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

`ifdef PS2_EVT_REPEAT_FILTER_EN
    localparam int unsigned SW = (HELD_SLOTS > 1) ? $clog2(HELD_SLOTS) : 1;

    logic [HELD_SLOTS-1:0] slot_vld;
    logic [8:0]            slot_key [HELD_SLOTS];
    logic [8:0]            key;
    logic                  hit;
    logic                  has_free;
    logic [SW-1:0]         hit_idx;
    logic [SW-1:0]         free_idx;
    logic                  take_slot;
    logic                  free_slot;

    // Held-table lookup: matching slot and lowest free slot
    always_comb begin
        key      = {evt.ext, evt.code};
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = int'(HELD_SLOTS) - 1; i >= 0; i--) begin
            if (slot_vld[i] && (slot_key[i] == key)) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
            if (!slot_vld[i]) begin
                has_free = 1'b1;
                free_idx = SW'(i);
            end
        end
        take_slot = emit && !evt.brk && !hit && has_free;
        free_slot = emit && evt.brk && hit;
        push      = emit && !(!evt.brk && hit);
    end

    // Held-table storage; updated even when the FIFO drops the event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld <= '0;
            for (int i = 0; i < int'(HELD_SLOTS); i++) begin
                slot_key[i] <= '0;
            end
        end else if (take_slot) begin
            slot_vld[free_idx] <= 1'b1;
            slot_key[free_idx] <= key;
        end else if (free_slot) begin
            slot_vld[hit_idx] <= 1'b0;
        end
    end

    // Occupied slot count tracked alongside the table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_count <= '0;
        end else if (take_slot) begin
            held_count <= held_count + 4'd1;
        end else if (free_slot) begin
            held_count <= held_count - 4'd1;
        end
    end
`else
    assign push       = emit;
    assign held_count = 4'd0;
`endif

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wdata    (evt),
        .ready    (out_ready),
        .valid    (out_valid),
        .rdata    (out_event),
        .level    (fifo_level),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue (DEPTH=4, HELD_SLOTS=4, TIMEOUT_CYCLES=8).
module tb_ps2_key_event_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HELD  = 4;
    localparam int unsigned TMO   = 8;

`ifdef PS2_EVT_REPEAT_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_event;
    logic [2:0] fifo_level;
    logic [3:0] held_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [9:0] got [$];
    logic [9:0] exp [$];

    ps2_key_event_queue #(
        .DEPTH          (DEPTH),
        .HELD_SLOTS     (HELD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_event  (out_event),
        .fifo_level (fifo_level),
        .held_count (held_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Record every event the consumer accepts
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(out_event);
    end

    // Caller is at posedge+1; byte is presented for exactly one cycle
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b need 0", out_valid); end
        checks++; if (out_event !== 10'h000) begin errors++; $display("FAIL reset_event got %h need 000", out_event); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d need 0", fifo_level); end
        checks++; if (held_count !== 4'd0) begin errors++; $display("FAIL reset_held got %0d need 0", held_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b need 0", overflow); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_key;
        got.delete();
        out_ready = 1'b1;
        send(8'h1C);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_lat_valid got %b need 1", out_valid); end
        checks++; if (out_event !== 10'h01C) begin errors++; $display("FAIL single_lat_event got %h need 01c", out_event); end
        checks++; if (held_count !== (FILT ? 4'd1 : 4'd0)) begin errors++; $display("FAIL single_held_make got %0d need %0d", held_count, FILT); end
        send(8'hF0); send(8'h1C);
        idle(3);
        exp = '{10'h01C, 10'h11C};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL single_count got %0d need %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL single_evt%0d got %h need %h", i, got[i], exp[i]); end
        end
        checks++; if (held_count !== 4'd0) begin errors++; $display("FAIL single_held_brk got %0d need 0", held_count); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level got %0d need 0", fifo_level); end
    endtask

    task automatic test_typematic;
        got.delete();
        repeat (5) send(8'h1C);
        send(8'hF0); send(8'h1C);
        idle(3);
        if (FILT) exp = '{10'h01C, 10'h11C};
        else      exp = '{10'h01C, 10'h01C, 10'h01C, 10'h01C, 10'h01C, 10'h11C};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL typematic_count got %0d need %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL typematic_evt%0d got %h need %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_two_held;
        got.delete();
        send(8'h1C); send(8'h1B); send(8'h1C); send(8'h1B);
        send(8'hF0); send(8'h1B); send(8'h1C);
        idle(3);
        if (FILT) exp = '{10'h01C, 10'h01B, 10'h11B};
        else      exp = '{10'h01C, 10'h01B, 10'h01C, 10'h01B, 10'h11B, 10'h01C};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL two_held_count got %0d need %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL two_held_evt%0d got %h need %h", i, got[i], exp[i]); end
        end
        checks++; if (held_count !== (FILT ? 4'd1 : 4'd0)) begin errors++; $display("FAIL two_held_held got %0d need %0d", held_count, FILT); end
        send(8'hF0); send(8'h1C);
        idle(3);
        checks++; if (held_count !== 4'd0) begin errors++; $display("FAIL two_held_release got %0d need 0", held_count); end
    endtask

    task automatic test_extended;
        got.delete();
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(3);
        exp = '{10'h275, 10'h375};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL ext_count got %0d need %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL ext_evt%0d got %h need %h", i, got[i], exp[i]); end
        end
        // Lone prefix abandoned after exactly TMO idle cycles; status bytes dropped;
        // duplicate prefixes ignored; breaks of unheld keys still emitted
        got.delete();
        send(8'hE0);
        idle(TMO);
        send(8'h1C);
        send(8'hFA); send(8'hAA); send(8'hEE); send(8'hFE); send(8'hFF); send(8'h00);
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'hF0); send(8'h1B);
        idle(3);
        exp = '{10'h01C, 10'h11C, 10'h375, 10'h11B};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL tmo_count got %0d need %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL tmo_evt%0d got %h need %h", i, got[i], exp[i]); end
        end
        checks++; if (held_count !== 4'd0) begin errors++; $display("FAIL tmo_held got %0d need 0", held_count); end
    endtask

    task automatic test_overflow;
        got.delete();
        out_ready = 1'b0;
        send(8'h10); send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        idle(1);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d need 4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b need 1", overflow); end
        checks++; if (out_event !== 10'h010) begin errors++; $display("FAIL ovf_head got %h need 010", out_event); end
        checks++; if (held_count !== (FILT ? 4'd4 : 4'd0)) begin errors++; $display("FAIL ovf_held got %0d need %0d", held_count, FILT ? 4 : 0); end
        // Push while full with a simultaneous pop
        in_valid  = 1'b1;
        in_data   = 8'h15;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_pushpop_level got %0d need 4", fifo_level); end
        checks++; if (out_event !== 10'h011) begin errors++; $display("FAIL ovf_pushpop_head got %h need 011", out_event); end
        out_ready = 1'b1;
        idle(6);
        exp = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h015};
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL ovf_count got %0d need %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL ovf_evt%0d got %h need %h", i, got[i], exp[i]); end
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drain_level got %0d need 0", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b need 1", overflow); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        send(8'h1C); send(8'hE0); send(8'hF0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b need 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b need 0", out_valid); end
        checks++; if (out_event !== 10'h000) begin errors++; $display("FAIL arst_event got %h need 000", out_event); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d need 0", fifo_level); end
        checks++; if (held_count !== 4'd0) begin errors++; $display("FAIL arst_held got %0d need 0", held_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_ovf got %b need 0", overflow); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        got.delete();
        out_ready = 1'b1;
        send(8'h75);
        checks++; if (out_event !== 10'h075) begin errors++; $display("FAIL arst_after_event got %h need 075", out_event); end
        idle(3);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL arst_after_count got %0d need 1", got.size()); end
        else begin
            checks++; if (got[0] !== 10'h075) begin errors++; $display("FAIL arst_after_evt got %h need 075", got[0]); end
        end
        checks++; if (held_count !== (FILT ? 4'd1 : 4'd0)) begin errors++; $display("FAIL arst_after_held got %0d need %0d", held_count, FILT); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_typematic();
        test_two_held();
        test_extended();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
